multi_cycle_control_fsm: RTL and testbench
==========================================

# multi_cycle_control_fsm

Sequencing controller for the multi-cycle RISC-V core. It steps each instruction through fetch, decode, execute, memory and write-back states. Each cycle it drives the select and strobe signals for the shared ALU, the unified instruction/data memory port, the IR/MDR/ALUOut latches, the PC and the register file. It stalls on a memory-ready handshake and holds in a terminal halt state after a halting ECALL.

## Interface
Parameters:
- none; opcode values come from `opcodes.v` (`ARITHMETIC`, `ARITHMETIC_IMM`, `LOAD`, `STORE`, `BRANCH`, `JAL`, `JALR`, `ECALL`).

Ports:
- clk  in  1  single clock, all state changes on its rising edge
- reset  in  1  synchronous, active-high
- opcode  in  7  IR[6:0], valid from ID onward
- mem_ready  in  1  memory completes the current read/write this cycle
- bcond  in  1  branch condition from ALU, valid in EX_BR
- halt_cond  in  1  datapath reports x17 == 10, valid in ECALL
- pc_write  out  1  PC load enable
- pc_source  out  1  0 = ALU result, 1 = ALUOut register
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- mem_to_reg  out  2  rd data: 00 ALUOut, 01 MDR, 10 ALU result
- write_enable  out  1  register-file write
- alu_src_a  out  1  0 = PC, 1 = A latch
- alu_src_b  out  2  00 = B latch, 01 = constant 4, 10 = immediate
- alu_op  out  2  00 add, 01 I-type funct, 10 R-type funct, 11 branch compare
- is_halted  out  1  sticky halt indicator
- state_dbg  out  4  current state encoding

## Operation
- State encoding: IF=0, ID=1, EX_R=2, EX_I=3, EX_ADDR=4, MEM_LD=5, WB_LD=6, MEM_ST=7, WB_ALU=8, EX_BR=9, EX_JAL=10, EX_JALR=11, JALR_WB=12, ECALL=13, PC4=14, HALT=15.
- Every output is 0 unless listed for the current state.
- "PC+4 update" means: alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0, pc_write=1.

States, outputs and transitions:
- IF: i_or_d=0, mem_read=1, ir_write=mem_ready. Stays in IF while !mem_ready, then goes to ID.
- ID: alu_src_a=0, alu_src_b=10, alu_op=00, so ALUOut latches PC+imm. Next state by opcode:
  - ARITHMETIC → EX_R
  - ARITHMETIC_IMM → EX_I
  - LOAD/STORE → EX_ADDR
  - BRANCH → EX_BR
  - JAL → EX_JAL
  - JALR → EX_JALR
  - ECALL → ECALL
  - any other opcode → PC4 (executes as a NOP)
- EX_R: alu_src_a=1, alu_src_b=00, alu_op=10 → WB_ALU.
- EX_I: alu_src_a=1, alu_src_b=10, alu_op=01 → WB_ALU.
- WB_ALU: write_enable=1, mem_to_reg=00, plus PC+4 update → IF.
- EX_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 → MEM_LD if opcode==LOAD, else MEM_ST.
- MEM_LD: i_or_d=1, mem_read=1. Waits for mem_ready (datapath latches MDR then) → WB_LD.
- WB_LD: write_enable=1, mem_to_reg=01, plus PC+4 update → IF.
- MEM_ST: i_or_d=1, mem_write=1. When mem_ready, also performs the PC+4 update → IF. Otherwise holds, with no pc_write.
- EX_BR: alu_src_a=1, alu_src_b=00, alu_op=11.
  - bcond=1: pc_source=1, pc_write=1 → IF.
  - bcond=0: → PC4.
- EX_JAL: alu_src_a=0, alu_src_b=01, alu_op=00, mem_to_reg=10, write_enable=1 (rd=PC+4); pc_source=1, pc_write=1 → IF.
- EX_JALR: alu_src_a=1, alu_src_b=10, alu_op=00 (ALUOut=A+imm) → JALR_WB.
- JALR_WB: same outputs as EX_JAL → IF. Clearing the target's LSB is the datapath's job.
- ECALL:
  - halt_cond=1: no PC write → HALT.
  - halt_cond=0: PC+4 update → IF.
- PC4: PC+4 update → IF.
- HALT: all strobes 0, is_halted=1. Stays in HALT until reset.
- An instruction never writes both memory and the register file.

## Timing
- Reset:
  - While reset=1, every output is forced to 0, including is_halted and state_dbg.
  - At the rising edge with reset=1, state loads IF.
  - The first cycle after release is IF.
- Outputs are combinational from the state register, plus mem_ready, bcond and halt_cond in the states listed above.
- Cycle counts with zero memory wait:

| Instruction | Cycles |
|---|---|
| R/I-type | 4 |
| load | 5 |
| store | 4 |
| taken branch | 3 |
| not-taken branch | 4 |
| JAL | 3 |
| JALR | 4 |
| ECALL (continue) | 3 |
| unknown opcode | 3 |

- Each cycle with mem_ready=0 in IF, MEM_LD or MEM_ST adds exactly one cycle. Strobes are held stable throughout the wait.
- opcode is sampled only in ID and EX_ADDR. Changes in other states have no effect.
- Reset asserted mid-instruction: the next state is IF. No partial write_enable, mem_write or pc_write is issued in the reset cycle.

## Test plan
- add x1,x2,x3 with mem_ready=1 → state_dbg sequence 0,1,2,8,0; write_enable=1 and pc_write=1 only in cycle 4.
- lw with mem_ready low for 2 cycles in MEM_LD → 0,1,4,5,5,5,6,0; mem_read and i_or_d=1 held across all three MEM_LD cycles; mem_to_reg=01 in WB_LD.
- beq, first with bcond=1, then with bcond=0:
  - bcond=1 → 0,1,9,0 with pc_source=1.
  - bcond=0 → 0,1,9,14,0 with pc_source=0 in PC4.
- jal then jalr → sequences 0,1,10 and 0,1,11,12. Each writes rd with mem_to_reg=10 and pc_source=1 together.
- ecall, first with halt_cond=0, then with halt_cond=1:
  - halt_cond=0 → returns to IF with pc_write=1.
  - halt_cond=1 → state 15 and is_halted=1, holding for 20 cycles under toggling inputs.
  - A subsequent reset pulse returns to state 0 with is_halted=0.
- Reset asserted in MEM_ST while mem_ready=1 → mem_write=0 and pc_write=0 that cycle, then state 0.

Source files
------------

// File: rtl/multi_cycle_control_fsm.sv
// Sequencing controller for the multi-cycle RISC-V core: walks each instruction
// through IF/ID/EX/MEM/WB and drives every datapath select and strobe.
module multi_cycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       bcond,
  input  logic       halt_cond,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] mem_to_reg,
  output logic       write_enable,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_halted,
  output logic [3:0] state_dbg
);

  localparam logic [6:0] ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] LOAD           = 7'b0000011;
  localparam logic [6:0] STORE          = 7'b0100011;
  localparam logic [6:0] BRANCH         = 7'b1100011;
  localparam logic [6:0] JAL            = 7'b1101111;
  localparam logic [6:0] JALR           = 7'b1100111;
  localparam logic [6:0] ECALL          = 7'b1110011;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_MEM_LD  = 4'd5,
    S_WB_LD   = 4'd6,
    S_MEM_ST  = 4'd7,
    S_WB_ALU  = 4'd8,
    S_EX_BR   = 4'd9,
    S_EX_JAL  = 4'd10,
    S_EX_JALR = 4'd11,
    S_JALR_WB = 4'd12,
    S_ECALL   = 4'd13,
    S_PC4     = 4'd14,
    S_HALT    = 4'd15
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register with synchronous reset into fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; everything is held at 0 while reset is high.
  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b0;
    pc_source    = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mem_to_reg   = 2'b00;
    write_enable = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    is_halted    = 1'b0;
    state_dbg    = 4'd0;
    if (reset) begin
      state_d = S_IF;
    end else begin
      state_dbg = state_q;
      case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          state_d  = mem_ready ? S_ID : S_IF;
        end
        S_ID: begin
          alu_src_b = 2'b10;
          case (opcode)
            ARITHMETIC:     state_d = S_EX_R;
            ARITHMETIC_IMM: state_d = S_EX_I;
            LOAD, STORE:    state_d = S_EX_ADDR;
            BRANCH:         state_d = S_EX_BR;
            JAL:            state_d = S_EX_JAL;
            JALR:           state_d = S_EX_JALR;
            ECALL:          state_d = S_ECALL;
            default:        state_d = S_PC4;
          endcase
        end
        S_EX_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_WB_ALU;
        end
        S_EX_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b01;
          state_d   = S_WB_ALU;
        end
        S_WB_ALU: begin
          write_enable = 1'b1;
          alu_src_b    = 2'b01;
          pc_write     = 1'b1;
          state_d      = S_IF;
        end
        S_EX_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == LOAD) ? S_MEM_LD : S_MEM_ST;
        end
        S_MEM_LD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
          state_d  = mem_ready ? S_WB_LD : S_MEM_LD;
        end
        S_WB_LD: begin
          write_enable = 1'b1;
          mem_to_reg   = 2'b01;
          alu_src_b    = 2'b01;
          pc_write     = 1'b1;
          state_d      = S_IF;
        end
        S_MEM_ST: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
            state_d   = S_IF;
          end else begin
            state_d = S_MEM_ST;
          end
        end
        S_EX_BR: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b11;
          if (bcond) begin
            pc_source = 1'b1;
            pc_write  = 1'b1;
            state_d   = S_IF;
          end else begin
            state_d = S_PC4;
          end
        end
        S_EX_JAL, S_JALR_WB: begin
          // rd gets PC+4 from the live ALU while the PC loads the target from ALUOut.
          alu_src_b    = 2'b01;
          mem_to_reg   = 2'b10;
          write_enable = 1'b1;
          pc_source    = 1'b1;
          pc_write     = 1'b1;
          state_d      = S_IF;
        end
        S_EX_JALR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_JALR_WB;
        end
        S_ECALL: begin
          if (halt_cond) begin
            state_d = S_HALT;
          end else begin
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
            state_d   = S_IF;
          end
        end
        S_PC4: begin
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
          state_d   = S_IF;
        end
        S_HALT: begin
          is_halted = 1'b1;
          state_d   = S_HALT;
        end
        default: begin
          state_d = S_IF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Directed bench for multi_cycle_control_fsm: per-cycle expected state and
// control vectors are queued as stimulus is driven and checked on the falling edge.
module tb_multi_cycle_control_fsm;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ECA  = 7'b1110011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset, mem_ready, bcond, halt_cond;
  logic [6:0] opcode;
  logic       pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] mem_to_reg, alu_src_b, alu_op;
  logic       write_enable, alu_src_a, is_halted;
  logic [3:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [18:0] exp_q[$];

  multi_cycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .bcond(bcond), .halt_cond(halt_cond), .pc_write(pc_write),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .write_enable(write_enable), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .is_halted(is_halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // {pc_write,pc_source,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,write_enable,alu_src_a,alu_src_b,alu_op,is_halted}
  function automatic logic [14:0] ctl(input logic pw, ps, iord, mr, mw, irw,
                                      input logic [1:0] m2r, input logic we, asa,
                                      input logic [1:0] asb, aop, input logic hlt);
    return {pw, ps, iord, mr, mw, irw, m2r, we, asa, asb, aop, hlt};
  endfunction

  function automatic logic [14:0] c_pc4();
    return ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] c_if(input logic rdy);
    return ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] c_id();
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] c_aimm(input logic [1:0] aop);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, aop, 1'b0);
  endfunction
  function automatic logic [14:0] c_exr();
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0);
  endfunction
  function automatic logic [14:0] c_wb(input logic [1:0] m2r);
    return ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m2r, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] c_memld();
    return ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] c_memst(input logic rdy);
    return ctl(rdy, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, rdy ? 2'b01 : 2'b00, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] c_br(input logic b);
    return ctl(b, b, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11, 1'b0);
  endfunction
  function automatic logic [14:0] c_jal();
    return ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] c_halt();
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
  endfunction

  // One clock cycle: drive inputs, queue the expectation, check at negedge.
  task automatic step(input logic [6:0] op, input logic rdy, bc, hc, rst,
                      input logic [3:0] es, input logic [14:0] ec, input string tag);
    logic [18:0] e;
    logic [14:0] obs;
    opcode    = op;
    mem_ready = rdy;
    bcond     = bc;
    halt_cond = hc;
    reset     = rst;
    exp_q.push_back({es, ec});
    @(negedge clk);
    e   = exp_q.pop_front();
    obs = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           write_enable, alu_src_a, alu_src_b, alu_op, is_halted};
    checks++;
    assert (state_dbg === e[18:15]) else begin
      failures++;
      $error("FAIL %s.state observed=%0d expected=%0d", tag, state_dbg, e[18:15]);
    end
    checks++;
    assert (obs === e[14:0]) else begin
      failures++;
      $error("FAIL %s.ctl observed=%b expected=%b", tag, obs, e[14:0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; mem_ready = 1'b0; bcond = 1'b0; halt_cond = 1'b0;
    @(posedge clk);
    #1;
    step(OP_R, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 15'd0, "reset");

    // add with an opcode change during EX_R that must be ignored
    step(OP_R,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b1), "add.if");
    step(OP_R,  1'b1, 1'b0, 1'b0, 1'b0, 4'd1, c_id(), "add.id");
    step(OP_LD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, c_exr(), "add.exr");
    step(OP_LD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, c_wb(2'b00), "add.wb");

    // addi with a fetch stall
    step(OP_I, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b0), "addi.ifwait");
    step(OP_I, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b1), "addi.if");
    step(OP_I, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, c_id(), "addi.id");
    step(OP_I, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, c_aimm(2'b01), "addi.exi");
    step(OP_I, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, c_wb(2'b00), "addi.wb");

    // lw with two wait cycles in MEM_LD
    step(OP_LD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b1), "lw.if");
    step(OP_LD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, c_id(), "lw.id");
    step(OP_LD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, c_aimm(2'b00), "lw.addr");
    step(OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, c_memld(), "lw.mem0");
    step(OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, c_memld(), "lw.mem1");
    step(OP_LD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, c_memld(), "lw.mem2");
    step(OP_LD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, c_wb(2'b01), "lw.wb");

    // sw with one wait cycle
    step(OP_ST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b1), "sw.if");
    step(OP_ST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, c_id(), "sw.id");
    step(OP_ST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, c_aimm(2'b00), "sw.addr");
    step(OP_ST, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, c_memst(1'b0), "sw.mem0");
    step(OP_ST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7, c_memst(1'b1), "sw.mem1");

    // beq taken then not taken
    step(OP_BR, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, c_if(1'b1), "beqt.if");
    step(OP_BR, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, c_id(), "beqt.id");
    step(OP_BR, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, c_br(1'b1), "beqt.ex");
    step(OP_BR, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b1), "beqn.if");
    step(OP_BR, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, c_id(), "beqn.id");
    step(OP_BR, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, c_br(1'b0), "beqn.ex");
    step(OP_BR, 1'b1, 1'b1, 1'b0, 1'b0, 4'd14, c_pc4(), "beqn.pc4");

    // jal then jalr
    step(OP_JAL,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b1), "jal.if");
    step(OP_JAL,  1'b1, 1'b0, 1'b0, 1'b0, 4'd1, c_id(), "jal.id");
    step(OP_JAL,  1'b1, 1'b0, 1'b0, 1'b0, 4'd10, c_jal(), "jal.ex");
    step(OP_JALR, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b1), "jalr.if");
    step(OP_JALR, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, c_id(), "jalr.id");
    step(OP_JALR, 1'b1, 1'b0, 1'b0, 1'b0, 4'd11, c_aimm(2'b00), "jalr.ex");
    step(OP_JALR, 1'b1, 1'b0, 1'b0, 1'b0, 4'd12, c_jal(), "jalr.wb");

    // unknown opcode executes as a NOP
    step(OP_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b1), "nop.if");
    step(OP_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, c_id(), "nop.id");
    step(OP_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd14, c_pc4(), "nop.pc4");

    // reset in MEM_ST with mem_ready high suppresses the write
    step(OP_ST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b1), "swr.if");
    step(OP_ST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, c_id(), "swr.id");
    step(OP_ST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, c_aimm(2'b00), "swr.addr");
    step(OP_ST, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 15'd0, "swr.rst");
    step(OP_ST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b1), "swr.after");

    // ecall continue
    step(OP_ECA, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, c_id(), "ecc.id");
    step(OP_ECA, 1'b1, 1'b0, 1'b0, 1'b0, 4'd13, c_pc4(), "ecc.ex");

    // ecall halt, then held under toggling inputs
    step(OP_ECA, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, c_if(1'b1), "ech.if");
    step(OP_ECA, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, c_id(), "ech.id");
    step(OP_ECA, 1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 15'd0, "ech.ex");
    for (int i = 0; i < 20; i++) begin
      step(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
           4'd15, c_halt(), "halt.hold");
    end
    step(OP_R, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 15'd0, "halt.rst");
    step(OP_R, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, c_if(1'b1), "halt.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
